// File: rtl/stats_pkg.sv
// Shared definitions for the performance-statistics counter bank:
// stat identifiers, counter type and controller FSM states.
package stats_pkg;

    localparam int unsigned NUM_CNT = 5;
    localparam int unsigned ID_W    = $clog2(NUM_CNT);

    typedef logic [63:0] uint64_t;

    typedef enum logic [ID_W-1:0] {
        STAT_CYCLES,
        STAT_WAIT_INSN_FETCH,
        STAT_WAIT_OPERAND_FETCH,
        STAT_VEC_LOCAL_DIVERGENCE,
        STAT_L1I_HIT
    } stat_id_t;

    typedef enum logic [1:0] {
        StIdle,
        StSnap,
        StStream,
        StClear
    } state_e;

endpackage

// File: rtl/stats_popcount.sv
// Combinational population count of N_SRC event bits for one statistic.
module stats_popcount #(
    parameter int unsigned N_SRC = 4,
    localparam int unsigned CW   = $clog2(N_SRC + 1)
) (
    input  logic [N_SRC-1:0] in_bits,
    output logic [CW-1:0]    count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N_SRC; i++) begin
            count = count + CW'(in_bits[i]);
        end
    end

endmodule

// File: rtl/stats_event_collector.sv
// Merges per-source event pulses into one counter per statistic through a
// two-stage delta/add pipeline and streams snapshots out on request.
module stats_event_collector
    import stats_pkg::*;
#(
    parameter int unsigned N_SRC         = 4,
    parameter int unsigned CNT_W         = 64,
    parameter bit          CLEAR_ON_DUMP = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     count_en,
    input  logic [N_SRC*NUM_CNT-1:0] ev_i,
    input  logic                     dump_req,
    input  logic                     clear_req,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output stat_id_t                 out_id,
    output logic [CNT_W-1:0]         out_value,
    output logic                     out_last
);

    localparam int unsigned DW     = $clog2(N_SRC + 1);
    localparam stat_id_t    LastId = stat_id_t'(NUM_CNT - 1);

    state_e                        state_q, state_d;
    stat_id_t                      idx_q, idx_d;
    logic                          pending_clear_q, pending_clear_d;
    logic [NUM_CNT-1:0][DW-1:0]    delta_q, delta_d, pop;
    logic [NUM_CNT-1:0][CNT_W-1:0] cnt_q, cnt_d, snap_q, snap_d;

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_stat
        logic [N_SRC-1:0] src_bits;
        for (genvar s = 0; s < N_SRC; s++) begin : g_src
            assign src_bits[s] = ev_i[s*NUM_CNT+g];
        end
        if (g == int'(STAT_CYCLES)) begin : g_cycles
            // The cycle counter ignores its event lane and ticks once per enabled cycle.
            logic unused_src_bits;
            assign unused_src_bits = ^src_bits;
            assign pop[g]          = DW'(1);
        end else begin : g_events
            stats_popcount #(
                .N_SRC(N_SRC)
            ) u_popcount (
                .in_bits(src_bits),
                .count  (pop[g])
            );
        end
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        pending_clear_d = pending_clear_q;
        snap_d          = snap_q;
        busy            = (state_q != StIdle);
        out_valid       = 1'b0;
        out_id          = STAT_CYCLES;
        out_value       = '0;
        out_last        = 1'b0;
        for (int i = 0; i < NUM_CNT; i++) begin
            delta_d[i] = count_en ? pop[i] : '0;
            cnt_d[i]   = cnt_q[i] + CNT_W'(delta_q[i]);
        end

        case (state_q)
            StIdle: begin
                if (dump_req) begin
                    state_d         = StSnap;
                    pending_clear_d = clear_req;
                end else if (clear_req) begin
                    state_d = StClear;
                end
            end
            StSnap: begin
                // Captures the pre-add value; the delta committing on this edge is excluded.
                snap_d  = cnt_q;
                idx_d   = STAT_CYCLES;
                state_d = StStream;
            end
            StStream: begin
                out_valid = 1'b1;
                out_id    = idx_q;
                out_value = snap_q[idx_q];
                out_last  = (idx_q == LastId);
                if (out_ready) begin
                    if (idx_q == LastId) begin
                        state_d         = (CLEAR_ON_DUMP || pending_clear_q) ? StClear : StIdle;
                        pending_clear_d = 1'b0;
                    end else begin
                        idx_d = stat_id_t'(idx_q + 1'b1);
                    end
                end
            end
            StClear: begin
                cnt_d   = '0;
                delta_d = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            idx_q           <= STAT_CYCLES;
            pending_clear_q <= 1'b0;
            delta_q         <= '0;
            cnt_q           <= '0;
            snap_q          <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            pending_clear_q <= pending_clear_d;
            delta_q         <= delta_d;
            cnt_q           <= cnt_d;
            snap_q          <= snap_d;
        end
    end

endmodule

// File: tb/tb_stats_event_collector.sv
// Directed bench for stats_event_collector: counting, wrap, stalled dump,
// dump+clear pairing, ignored requests and asynchronous reset mid-stream.
module tb_stats_event_collector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        count_en;
    logic [19:0] ev_i;
    logic        dump_req;
    logic        clear_req;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_id;
    logic [63:0] out_value;
    logic        out_last;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] dv [5];

    always #5 clk = ~clk;

    stats_event_collector dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .count_en (count_en),
        .ev_i     (ev_i),
        .dump_req (dump_req),
        .clear_req(clear_req),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_id   (out_id),
        .out_value(out_value),
        .out_last (out_last)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Requests a dump and collects all words into dv[].
    task automatic do_dump(input bit toggle, input bit ev_during, input bit clr_with,
                           input bit clr_during);
        int          n;
        bit          stalled;
        logic [2:0]  sid;
        logic [63:0] sval;
        dump_req  = 1'b1;
        clear_req = clr_with;
        tick();
        dump_req  = 1'b0;
        clear_req = 1'b0;
        tick();
        n       = 0;
        stalled = 1'b0;
        for (int c = 0; c < 60 && n < 5; c++) begin
            out_ready = toggle ? c[0] : 1'b1;
            clear_req = clr_during && (c == 1);
            if (ev_during) begin
                count_en = 1'b1;
                ev_i     = '1;
            end
            if (stalled) begin
                check("stall_id", 64'(out_id), 64'(sid));
                check("stall_val", out_value, sval);
            end
            stalled = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    check($sformatf("word_id%0d", n), 64'(out_id), 64'(n));
                    check($sformatf("word_last%0d", n), 64'(out_last), 64'(n == 4));
                    dv[n] = out_value;
                    n++;
                end else begin
                    stalled = 1'b1;
                    sid     = out_id;
                    sval    = out_value;
                end
            end
            tick();
        end
        out_ready = 1'b0;
        clear_req = 1'b0;
        ev_i      = '0;
        if (ev_during) count_en = 1'b0;
        check("dump_words", 64'(n), 64'd5);
    endtask

    task automatic check_vals(input string t, input logic [63:0] e0, input logic [63:0] e1,
                              input logic [63:0] e2, input logic [63:0] e3,
                              input logic [63:0] e4);
        check({t, "_v0"}, dv[0], e0);
        check({t, "_v1"}, dv[1], e1);
        check({t, "_v2"}, dv[2], e2);
        check({t, "_v3"}, dv[3], e3);
        check({t, "_v4"}, dv[4], e4);
    endtask

    logic [4:0][63:0] fv;

    initial begin
        rst_n     = 1'b0;
        count_en  = 1'b0;
        ev_i      = '0;
        dump_req  = 1'b0;
        clear_req = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_id", 64'(out_id), 64'd0);
        check("rst_value", out_value, 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick();

        // Ten enabled cycles.
        count_en = 1'b1;
        tick(10);
        count_en = 1'b0;
        tick(3);
        do_dump(1'b0, 1'b0, 1'b0, 1'b0);
        check_vals("t1", 64'd10, 64'd0, 64'd0, 64'd0, 64'd0);

        // All four sources hit L1I for 3 cycles, then one source once.
        count_en = 1'b1;
        ev_i     = 20'h84210;
        tick(3);
        ev_i = 20'h04000;
        tick();
        ev_i     = '0;
        count_en = 1'b0;
        tick(3);
        do_dump(1'b0, 1'b0, 1'b0, 1'b0);
        check_vals("t2", 64'd14, 64'd0, 64'd0, 64'd0, 64'd13);

        // Back-pressured dump with events landing during the stream.
        do_dump(1'b1, 1'b1, 1'b0, 1'b0);
        check_vals("t3", 64'd14, 64'd0, 64'd0, 64'd0, 64'd13);
        tick(3);

        // Wrap of a saturated counter.
        fv    = '0;
        fv[1] = '1;
        force dut.cnt_q = fv;
        tick();
        release dut.cnt_q;
        tick();
        count_en = 1'b1;
        ev_i     = 20'h00002;
        tick();
        ev_i     = '0;
        count_en = 1'b0;
        tick(3);
        do_dump(1'b0, 1'b0, 1'b0, 1'b0);
        check_vals("t4", 64'd1, 64'd0, 64'd0, 64'd0, 64'd0);

        // Same-cycle dump+clear: old values out, then cleared.
        do_dump(1'b0, 1'b0, 1'b1, 1'b0);
        check_vals("t5a", 64'd1, 64'd0, 64'd0, 64'd0, 64'd0);
        check("t5_clear_busy", 64'(busy), 64'd1);
        tick();
        check("t5_idle", 64'(busy), 64'd0);
        count_en = 1'b1;
        tick(4);
        count_en = 1'b0;
        tick(2);
        do_dump(1'b0, 1'b0, 1'b0, 1'b1);
        check_vals("t5b", 64'd4, 64'd0, 64'd0, 64'd0, 64'd0);
        check("t5_no_clear", 64'(busy), 64'd0);
        do_dump(1'b0, 1'b0, 1'b0, 1'b0);
        check_vals("t5c", 64'd4, 64'd0, 64'd0, 64'd0, 64'd0);

        // Reset mid-stream at idx 2.
        count_en = 1'b1;
        tick(3);
        count_en  = 1'b0;
        tick(2);
        out_ready = 1'b1;
        dump_req  = 1'b1;
        tick();
        dump_req = 1'b0;
        tick(3);
        out_ready = 1'b0;
        check("t6_idx", 64'(out_id), 64'd2);
        check("t6_valid_pre", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid_rst", 64'(out_valid), 64'd0);
        check("t6_busy_rst", 64'(busy), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_dump(1'b0, 1'b0, 1'b0, 1'b0);
        check_vals("t6", 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
